branch_resolve_unit: RTL and testbench

- Closes the loop for the hybrid branch predictor.
- Fetch pushes each branch/jump it predicted into an in-order queue; the execute stage later reports the actual outcome.
- The unit compares outcome against prediction and drives the predictor update interface (`Branch_instr`, `Branch_addr`, `Branch_resolved`, `Branch_resolved_addr`).
- On a misprediction it raises `FLUSH` with the correct-path `Redirect_addr` for the pipeline.

---
 rtl/branch_resolve_unit_if.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: groups the branch predictor's fetch, resolve and update signals.
// Ports (via modports):
//   master: drives Pred_* and Res_*; observes the update, flush, counter and flag outputs.
//   slave:  the resolve unit side, which is the mirror image of master.
interface branch_resolve_unit_if;
    logic        Pred_valid;
    logic [31:0] Pred_PC;
    logic [31:0] Pred_instr;
    logic        Pred_taken;
    logic [31:0] Pred_target;
    logic        Res_valid;
    logic        Res_taken;
    logic [31:0] Res_target;
    logic        Queue_full;
    logic        Update_valid;
    logic [31:0] Branch_instr;
    logic [31:0] Branch_addr;
    logic        Branch_resolved;
    logic [31:0] Branch_resolved_addr;
    logic        FLUSH;
    logic [31:0] Redirect_addr;
    logic [15:0] Mispredict_count;
    logic [15:0] Resolve_count;
    logic        Overflow;
    logic        Underflow;
    modport master (
        output Pred_valid, Pred_PC, Pred_instr, Pred_taken, Pred_target,
        output Res_valid, Res_taken, Res_target,
        input  Queue_full, Update_valid, Branch_instr, Branch_addr, Branch_resolved,
        input  Branch_resolved_addr, FLUSH, Redirect_addr, Mispredict_count,
        input  Resolve_count, Overflow, Underflow
    );
    modport slave (
        input  Pred_valid, Pred_PC, Pred_instr, Pred_taken, Pred_target,
        input  Res_valid, Res_taken, Res_target,
        output Queue_full, Update_valid, Branch_instr, Branch_addr, Branch_resolved,
        output Branch_resolved_addr, FLUSH, Redirect_addr, Mispredict_count,
        output Resolve_count, Overflow, Underflow
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: matches resolved branch outcomes against queued predictions, updates the predictor and flushes on mispredict.
// Ports:
//   CLK, RESET: clock and synchronous active-high reset.
//   bus (slave): Pred_* push predictions, Res_* resolve the oldest one; Branch_* and Update_valid
//                drive the predictor update; FLUSH and Redirect_addr steer the pipeline;
//                counters, sticky Overflow/Underflow flags and Queue_full report status.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  CLK,
    input logic                  RESET,
    branch_resolve_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, RECOVER} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t      mem_q [DEPTH];
    state_t      state_q, state_d;
    logic [RW-1:0] rec_q, rec_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        upd_q, upd_d;
    logic [31:0] binstr_q, binstr_d;
    logic [31:0] baddr_q, baddr_d;
    logic        bres_q, bres_d;
    logic [31:0] bres_addr_q, bres_addr_d;
    logic [31:0] redir_q, redir_d;
    logic [15:0] mis_cnt_q, mis_cnt_d;
    logic [15:0] res_cnt_q, res_cnt_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    entry_t      head;
    logic        run, full, pop, mis, push;
    logic [31:0] next_pc;

    always_comb begin
        head    = mem_q[rd_q];
        run     = state_q == RUN;
        full    = cnt_q == CW'(DEPTH);
        pop     = run && bus.Res_valid && cnt_q != '0;
        next_pc = bus.Res_taken ? bus.Res_target : head.pc + 32'd4;
        // Not-taken outcomes never compare targets: only direction matters there.
        mis     = pop && (head.taken != bus.Res_taken ||
                          (head.taken && head.target != bus.Res_target));
        // A full queue accepts a push only when a correct pop frees the head slot this edge.
        push    = run && bus.Pred_valid && !mis && (!full || pop);
        rd_d    = mis ? '0 : pop  ? rd_q + AW'(1) : rd_q;
        wr_d    = mis ? '0 : push ? wr_q + AW'(1) : wr_q;
        cnt_d   = mis ? '0 : cnt_q + CW'(push) - CW'(pop);
        state_d = mis ? RECOVER : (!run && rec_q == '0) ? RUN : state_q;
        rec_d   = mis ? RW'(FLUSH_CYCLES - 1) : (!run && rec_q != '0) ? rec_q - RW'(1) : rec_q;
        upd_d       = pop;
        binstr_d    = pop ? head.instr : binstr_q;
        baddr_d     = pop ? head.pc : baddr_q;
        bres_d      = pop ? bus.Res_taken : bres_q;
        bres_addr_d = pop ? next_pc : bres_addr_q;
        redir_d     = mis ? next_pc : redir_q;
        res_cnt_d   = (pop && res_cnt_q != 16'hFFFF) ? res_cnt_q + 16'd1 : res_cnt_q;
        mis_cnt_d   = (mis && mis_cnt_q != 16'hFFFF) ? mis_cnt_q + 16'd1 : mis_cnt_q;
        ovf_d       = ovf_q | (run && bus.Pred_valid && full && !(pop && !mis));
        unf_d       = unf_q | (run && bus.Res_valid && cnt_q == '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= RUN;
            rec_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            upd_q       <= 1'b0;
            binstr_q    <= '0;
            baddr_q     <= '0;
            bres_q      <= 1'b0;
            bres_addr_q <= '0;
            redir_q     <= '0;
            mis_cnt_q   <= '0;
            res_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            upd_q       <= upd_d;
            binstr_q    <= binstr_d;
            baddr_q     <= baddr_d;
            bres_q      <= bres_d;
            bres_addr_q <= bres_addr_d;
            redir_q     <= redir_d;
            mis_cnt_q   <= mis_cnt_d;
            res_cnt_q   <= res_cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RESET)
            mem_q[wr_q] <= '{pc: bus.Pred_PC, instr: bus.Pred_instr,
                             taken: bus.Pred_taken, target: bus.Pred_target};
    end

    assign bus.Queue_full           = cnt_q == CW'(DEPTH);
    assign bus.Update_valid         = upd_q;
    assign bus.Branch_instr         = binstr_q;
    assign bus.Branch_addr          = baddr_q;
    assign bus.Branch_resolved      = bres_q;
    assign bus.Branch_resolved_addr = bres_addr_q;
    // FLUSH is exactly the registered RECOVER state.
    assign bus.FLUSH                = state_q == RECOVER;
    assign bus.Redirect_addr        = redir_q;
    assign bus.Mispredict_count     = mis_cnt_q;
    assign bus.Resolve_count        = res_cnt_q;
    assign bus.Overflow             = ovf_q;
    assign bus.Underflow            = unf_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus checked every cycle against a queue-based model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    branch_resolve_unit_if bif ();
    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (.CLK(CLK), .RESET(RESET), .bus(bif));

    int total = 0;
    int bad = 0;
    bit chk = 1'b0;

    function automatic void check(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
        end
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    int          rec_left = 0;
    logic        e_upd = 0, e_bres = 0, e_ovf = 0, e_unf = 0;
    logic [31:0] e_binstr = 0, e_baddr = 0, e_braddr = 0, e_redir = 0;
    int          e_mc = 0, e_rc = 0;
    ent_t        h;
    bit          popped, mis, full;
    logic [31:0] np;

    always @(posedge CLK) begin
        if (RESET) begin
            mq.delete();
            rec_left = 0;
            {e_upd, e_bres, e_ovf, e_unf} = '0;
            {e_binstr, e_baddr, e_braddr, e_redir} = '0;
            e_mc = 0;
            e_rc = 0;
        end else begin
            e_upd = 0;
            if (rec_left > 0) rec_left--;
            else begin
                full = mq.size() == DEPTH;
                popped = bif.Res_valid && mq.size() > 0;
                mis = 0;
                if (bif.Res_valid && mq.size() == 0) e_unf = 1;
                if (popped) begin
                    h = mq.pop_front();
                    np = bif.Res_taken ? bif.Res_target : h.pc + 32'd4;
                    mis = (h.taken != bif.Res_taken) || (h.taken && bif.Res_taken && h.tgt != bif.Res_target);
                    e_upd = 1;
                    e_binstr = h.instr;
                    e_baddr = h.pc;
                    e_bres = bif.Res_taken;
                    e_braddr = np;
                    if (e_rc < 65535) e_rc++;
                end
                if (mis) begin
                    mq.delete();
                    rec_left = FC;
                    e_redir = np;
                    if (e_mc < 65535) e_mc++;
                end
                if (bif.Pred_valid && full && !(popped && !mis)) e_ovf = 1;
                if (bif.Pred_valid && !mis && (!full || popped))
                    mq.push_back('{pc: bif.Pred_PC, instr: bif.Pred_instr, taken: bif.Pred_taken, tgt: bif.Pred_target});
            end
        end
    end

    always @(negedge CLK) begin
        if (chk) begin
            check("Update_valid", {31'd0, bif.Update_valid}, {31'd0, e_upd});
            check("Branch_instr", bif.Branch_instr, e_binstr);
            check("Branch_addr", bif.Branch_addr, e_baddr);
            check("Branch_resolved", {31'd0, bif.Branch_resolved}, {31'd0, e_bres});
            check("Branch_resolved_addr", bif.Branch_resolved_addr, e_braddr);
            check("FLUSH", {31'd0, bif.FLUSH}, {31'd0, rec_left > 0});
            check("Redirect_addr", bif.Redirect_addr, e_redir);
            check("Mispredict_count", {16'd0, bif.Mispredict_count}, e_mc);
            check("Resolve_count", {16'd0, bif.Resolve_count}, e_rc);
            check("Overflow", {31'd0, bif.Overflow}, {31'd0, e_ovf});
            check("Underflow", {31'd0, bif.Underflow}, {31'd0, e_unf});
            check("Queue_full", {31'd0, bif.Queue_full}, {31'd0, mq.size() == DEPTH});
        end
    end

    task automatic cyc(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic rv, input logic rt, input logic [31:0] rtg);
        bif.Pred_valid = pv;
        bif.Pred_PC = pc;
        bif.Pred_instr = pc ^ 32'hA5A5_0000;
        bif.Pred_taken = pt;
        bif.Pred_target = ptg;
        bif.Res_valid = rv;
        bif.Res_taken = rt;
        bif.Res_target = rtg;
        @(negedge CLK);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        cyc(1, pc, pt, ptg, 0, 0, 0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtg);
        cyc(0, 0, 0, 0, 1, rt, rtg);
    endtask

    logic [31:0] exp_pcs [4];

    initial begin
        bif.Pred_valid = 0;
        bif.Pred_PC = 0;
        bif.Pred_instr = 0;
        bif.Pred_taken = 0;
        bif.Pred_target = 0;
        bif.Res_valid = 0;
        bif.Res_taken = 0;
        bif.Res_target = 0;
        @(negedge CLK);
        chk = 1'b1;
        idle();
        RESET = 1'b0;
        idle();
        check("reset Update_valid", {31'd0, bif.Update_valid}, 0);
        check("reset Queue_full", {31'd0, bif.Queue_full}, 0);
        check("reset FLUSH", {31'd0, bif.FLUSH}, 0);
        check("reset Resolve_count", {16'd0, bif.Resolve_count}, 0);

        push(32'h100, 1, 32'h200);
        resolve(1, 32'h200);
        check("t2 Update_valid", {31'd0, bif.Update_valid}, 1);
        check("t2 Branch_addr", bif.Branch_addr, 32'h100);
        check("t2 Branch_resolved", {31'd0, bif.Branch_resolved}, 1);
        check("t2 Branch_resolved_addr", bif.Branch_resolved_addr, 32'h200);
        check("t2 FLUSH", {31'd0, bif.FLUSH}, 0);
        check("t2 Resolve_count", {16'd0, bif.Resolve_count}, 1);
        idle();
        check("t2 strobe drop", {31'd0, bif.Update_valid}, 0);

        push(32'h40, 1, 32'h80);
        push(32'h44, 0, 0);
        push(32'h48, 0, 0);
        cyc(1, 32'h4C, 0, 0, 1, 0, 0);
        check("t3 FLUSH c1", {31'd0, bif.FLUSH}, 1);
        check("t3 Redirect_addr", bif.Redirect_addr, 32'h44);
        check("t3 Mispredict_count", {16'd0, bif.Mispredict_count}, 1);
        cyc(1, 32'h500, 0, 0, 1, 1, 32'h999);
        check("t3 FLUSH c2", {31'd0, bif.FLUSH}, 1);
        check("t3 no update in recover", {31'd0, bif.Update_valid}, 0);
        idle();
        check("t3 FLUSH off", {31'd0, bif.FLUSH}, 0);
        resolve(0, 0);
        check("t5 Underflow", {31'd0, bif.Underflow}, 1);
        check("t5 no update", {31'd0, bif.Update_valid}, 0);

        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 0, 0);
        check("t4 Queue_full", {31'd0, bif.Queue_full}, 1);
        push(32'h2000, 0, 0);
        check("t4 Overflow", {31'd0, bif.Overflow}, 1);
        cyc(1, 32'h3000, 0, 0, 1, 0, 32'h1234);
        check("t4 pop addr", bif.Branch_addr, 32'h1000);
        check("t4 still full", {31'd0, bif.Queue_full}, 1);
        check("t4 no flush", {31'd0, bif.FLUSH}, 0);
        exp_pcs = '{32'h1004, 32'h1008, 32'h100C, 32'h3000};
        for (int i = 0; i < 4; i++) begin
            resolve(0, 0);
            check("t4 drain order", bif.Branch_addr, exp_pcs[i]);
        end
        check("t4 drained", {31'd0, bif.Queue_full}, 0);

        for (int i = 0; i < 10; i++) begin
            push(32'h6000 + 32'(4 * i), 0, 0);
            resolve(0, 0);
            check("wrap Branch_addr", bif.Branch_addr, 32'h6000 + 32'(4 * i));
            check("wrap next pc", bif.Branch_resolved_addr, 32'h6004 + 32'(4 * i));
        end

        push(32'h7000, 1, 32'h7100);
        resolve(1, 32'h7200);
        check("t6 FLUSH", {31'd0, bif.FLUSH}, 1);
        check("t6 Redirect_addr", bif.Redirect_addr, 32'h7200);
        RESET = 1'b1;
        idle();
        RESET = 1'b0;
        check("t6 FLUSH after reset", {31'd0, bif.FLUSH}, 0);
        check("t6 Mispredict_count", {16'd0, bif.Mispredict_count}, 0);
        check("t6 Resolve_count", {16'd0, bif.Resolve_count}, 0);

        for (int i = 0; i < 3000; i++) begin
            logic pt, rt;
            logic [31:0] ptg, rtg;
            pt = 1'($urandom);
            ptg = ($urandom % 2) ? 32'h100 : 32'h200;
            rt = ($urandom % 5 == 0) ? ~pt : pt;
            rtg = ($urandom % 4 == 0) ? 32'h300 : ptg;
            RESET = ($urandom % 250 == 0);
            cyc($urandom % 3 != 0, {$urandom, 2'b00} & 32'hFFFF_FFFC, pt, ptg,
                $urandom % 2 == 0, rt, rtg);
        end
        RESET = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
